// File: rtl/rom_fetch_master_if.sv
// Single-port synchronous ROM/RAM request interface.
// The master presents a word-aligned byte address; the slave returns the
// addressed word one clock later.
interface if_ram_1way;
    logic [31:0] ram_addr;
    logic [31:0] ram_rdata;

    modport MASTER (
        output ram_addr,
        input  ram_rdata
    );

    modport SLAVE (
        input  ram_addr,
        output ram_rdata
    );
endinterface

// File: rtl/rom_fetch_master.sv
// Instruction-fetch master.
// Walks a sequential PC over a one-cycle-latency ROM, keeps at most one read
// in flight and buffers up to two fetched words in a head/tail register pair
// so decode back-pressure never drops a word. A redirect flushes everything
// and restarts fetch at the (word-aligned) target.
module rom_fetch_master #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rstn,
    if_ram_1way.MASTER        if_rom,
    input  logic              jmp_i,
    input  logic [31:0]       jmp_addr_i,
    output logic [31:0]       instr_o,
    output logic [31:0]       instr_addr_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i
);

    // Clear the two low address bits of a redirect target.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Architectural state
    logic [31:0] pc_r;
    logic        inflight_r;
    logic [31:0] inflight_addr_r;
    logic [31:0] head_addr_r;
    logic [31:0] head_data_r;
    logic [31:0] tail_addr_r;
    logic [31:0] tail_data_r;
    logic [1:0]  count_r;
    logic        valid_r;

    // Next-state values
    logic        pop_s;
    logic [1:0]  cnt_pop_s;
    logic [2:0]  occ_s;
    logic        issue_s;
    logic [31:0] head_addr_s;
    logic [31:0] head_data_s;
    logic [31:0] tail_addr_s;
    logic [31:0] tail_data_s;
    logic [1:0]  count_s;

    // Pop, occupancy, issue decision and FIFO next state (pop before push).
    always_comb begin
        pop_s       = valid_r & instr_ready_i;
        cnt_pop_s   = count_r - {1'b0, pop_s};
        occ_s       = {1'b0, cnt_pop_s} + {2'b00, inflight_r};
        issue_s     = (occ_s < 3'd2) && !jmp_i;
        head_addr_s = head_addr_r;
        head_data_s = head_data_r;
        tail_addr_s = tail_addr_r;
        tail_data_s = tail_data_r;
        count_s     = cnt_pop_s;
        if (pop_s) begin
            head_addr_s = tail_addr_r;
            head_data_s = tail_data_r;
        end else begin
            head_addr_s = head_addr_r;
            head_data_s = head_data_r;
        end
        if (inflight_r) begin
            if (cnt_pop_s == 2'd0) begin
                head_addr_s = inflight_addr_r;
                head_data_s = if_rom.ram_rdata;
            end else begin
                tail_addr_s = inflight_addr_r;
                tail_data_s = if_rom.ram_rdata;
            end
            count_s = cnt_pop_s + 2'd1;
        end else begin
            count_s = cnt_pop_s;
        end
    end

    // State update: async reset, redirect flush, otherwise issue/capture/pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_r            <= BOOT_ADDR;
            inflight_r      <= 1'b0;
            inflight_addr_r <= 32'h0000_0000;
            head_addr_r     <= 32'h0000_0000;
            head_data_r     <= 32'h0000_0000;
            tail_addr_r     <= 32'h0000_0000;
            tail_data_r     <= 32'h0000_0000;
            count_r         <= 2'd0;
            valid_r         <= 1'b0;
        end else if (jmp_i) begin
            pc_r            <= align_word(jmp_addr_i);
            inflight_r      <= 1'b0;
            inflight_addr_r <= 32'h0000_0000;
            head_addr_r     <= 32'h0000_0000;
            head_data_r     <= 32'h0000_0000;
            tail_addr_r     <= 32'h0000_0000;
            tail_data_r     <= 32'h0000_0000;
            count_r         <= 2'd0;
            valid_r         <= 1'b0;
        end else begin
            if (issue_s) begin
                inflight_r      <= 1'b1;
                inflight_addr_r <= pc_r;
                pc_r            <= pc_r + 32'd4;
            end else begin
                inflight_r      <= 1'b0;
                inflight_addr_r <= inflight_addr_r;
                pc_r            <= pc_r;
            end
            head_addr_r <= head_addr_s;
            head_data_r <= head_data_s;
            tail_addr_r <= tail_addr_s;
            tail_data_r <= tail_data_s;
            count_r     <= count_s;
            valid_r     <= (count_s != 2'd0);
        end
    end

    assign if_rom.ram_addr = pc_r;
    assign instr_o         = head_data_r;
    assign instr_addr_o    = head_addr_r;
    assign instr_valid_o   = valid_r;

endmodule

// File: tb/tb_rom_fetch_master.sv
// Directed bench for rom_fetch_master with a scoreboard of expected
// {addr, word} pairs. ROM content: word at byte address A is A >> 2.
module tb_rom_fetch_master;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        rstn;
    logic        jmp_i;
    logic [31:0] jmp_addr_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    if_ram_1way rom_if ();

    int   total;
    int   bad;
    int   pops;
    int   p0;
    ent_t q[$];

    rom_fetch_master #(.BOOT_ADDR(32'h0000_0000)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .if_rom        (rom_if.MASTER),
        .jmp_i         (jmp_i),
        .jmp_addr_i    (jmp_addr_i),
        .instr_o       (instr_o),
        .instr_addr_o  (instr_addr_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i)
    );

    // Free-running clock, 10 time units period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM model: one cycle read latency.
    always @(posedge clk) begin
        rom_if.ram_rdata <= rom_if.ram_addr >> 2;
    end

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push_from(input logic [31:0] start, input int n);
        ent_t e;
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            e.a = a;
            e.d = rom_word(a);
            q.push_back(e);
            a = a + 32'd4;
        end
    endtask

    // Score the handshake of the current cycle, apply redirect flush, advance.
    task automatic tick();
        ent_t e;
        if (instr_valid_o === 1'b1 && instr_ready_i === 1'b1) begin
            pops++;
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL sb_extra: got addr %h want no word", instr_addr_o);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_addr", instr_addr_o, e.a);
                chk("sb_data", instr_o, e.d);
            end
        end
        if (jmp_i) begin
            q.delete();
            push_from(jmp_addr_i & 32'hFFFF_FFFC, 16);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_jmp(input logic [31:0] addr);
        jmp_i      = 1'b1;
        jmp_addr_i = addr;
        tick();
        jmp_i      = 1'b0;
        jmp_addr_i = 32'h0000_0000;
    endtask

    task automatic stream(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, {31'd0, instr_valid_o}, 32'd1);
            tick();
        end
    endtask

    // Reset release scenario: cycles 0/1 empty, words flow from cycle 2.
    task automatic boot_sequence(input string tag);
        chk({tag, "_c0_valid"}, {31'd0, instr_valid_o}, 32'd0);
        chk({tag, "_c0_addr"}, rom_if.ram_addr, 32'h0000_0000);
        tick();
        chk({tag, "_c1_valid"}, {31'd0, instr_valid_o}, 32'd0);
        chk({tag, "_c1_addr"}, rom_if.ram_addr, 32'h0000_0004);
        tick();
        chk({tag, "_c2_valid"}, {31'd0, instr_valid_o}, 32'd1);
        chk({tag, "_c2_iaddr"}, instr_addr_o, 32'h0000_0000);
        chk({tag, "_c2_instr"}, instr_o, 32'h0000_0000);
    endtask

    // Directed sequence.
    initial begin
        total         = 0;
        bad           = 0;
        pops          = 0;
        rstn          = 1'b0;
        jmp_i         = 1'b0;
        jmp_addr_i    = 32'h0000_0000;
        instr_ready_i = 1'b1;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0000_0000);
        chk("rst_iaddr", instr_addr_o, 32'h0000_0000);
        chk("rst_ramaddr", rom_if.ram_addr, 32'h0000_0000);

        // Reset release, streaming with ready high
        @(negedge clk);
        rstn = 1'b1;
        push_from(32'h0000_0000, 40);
        boot_sequence("boot");
        stream("boot_stream", 8);

        // Back-pressure: head and ram_addr frozen for 5 cycles
        instr_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, instr_valid_o}, 32'd1);
            chk("bp_iaddr", instr_addr_o, q[0].a);
            chk("bp_instr", instr_o, q[0].d);
            chk("bp_ramaddr", rom_if.ram_addr, q[0].a + 32'd8);
            tick();
        end
        instr_ready_i = 1'b1;
        stream("bp_resume", 6);

        // Redirect to 0x103 with buffer occupied, read in flight, no pop
        instr_ready_i = 1'b0;
        do_jmp(32'h0000_0103);
        instr_ready_i = 1'b1;
        chk("jmp_t1_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("jmp_t1_ramaddr", rom_if.ram_addr, 32'h0000_0100);
        tick();
        chk("jmp_t2_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("jmp_t3_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("jmp_t3_iaddr", instr_addr_o, 32'h0000_0100);
        chk("jmp_t3_instr", instr_o, 32'h0000_0040);
        stream("jmp_stream", 4);

        // Redirect coinciding with a pop
        do_jmp(32'h0000_0300);
        chk("jpop_t1_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("jpop_t2_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("jpop_t3_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("jpop_t3_iaddr", instr_addr_o, 32'h0000_0300);
        chk("jpop_t3_instr", instr_o, 32'h0000_00C0);
        stream("jpop_stream", 3);

        // Back-to-back redirects: last one wins
        do_jmp(32'h0000_0020);
        chk("jj_t1_valid", {31'd0, instr_valid_o}, 32'd0);
        do_jmp(32'h0000_0040);
        chk("jj_t2_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("jj_t3_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("jj_t4_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("jj_t4_iaddr", instr_addr_o, 32'h0000_0040);
        chk("jj_t4_instr", instr_o, 32'h0000_0010);
        stream("jj_stream", 3);

        // Address wrap-around
        do_jmp(32'hFFFF_FFF8);
        chk("wrap_t1_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("wrap_t2_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("wrap_t3_iaddr", instr_addr_o, 32'hFFFF_FFF8);
        chk("wrap_t3_instr", instr_o, 32'h3FFF_FFFE);
        p0 = pops;
        stream("wrap_stream", 6);
        chk("wrap_pops", pops - p0, 32'd6);

        // Asynchronous reset between clock edges
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("arst_ramaddr", rom_if.ram_addr, 32'h0000_0000);
        chk("arst_instr", instr_o, 32'h0000_0000);
        chk("arst_iaddr", instr_addr_o, 32'h0000_0000);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        push_from(32'h0000_0000, 40);
        boot_sequence("reboot");
        stream("reboot_stream", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
